mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - two independent byte-serial load/store lanes in front of a byte-write memory
// Optional macro MA_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.

module mem_access_lane #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  ready,
  input  logic                  load,
  input  logic                  store,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [AWIDTH_MEM+1:0] addr,
  input  logic [DWIDTH-1:0]     wdata,
  output logic                  ce,
  output logic                  wr_en,
  output logic [3:0]            mask,
  output logic [AWIDTH_MEM-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic [DWIDTH-1:0]     rdata,
  output logic                  done,
  output logic [DWIDTH-1:0]     data,
  output logic                  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            byte_q;
  logic [1:0]            cnt;
  logic [1:0]            last;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [AWIDTH_MEM-1:0] mem_addr_q;
  logic [DWIDTH-1:0]     mem_wdata_q;
  logic [DWIDTH-1:0]     data_q;

  logic [1:0]            b_eff;
  logic [1:0]            last_eff;
  logic                  misalign;
  logic [DWIDTH-1:0]     shifted;
  logic [DWIDTH-1:0]     load_result;

  // Half and word accesses are force-aligned; the trap build rejects them before this matters.
  always_comb begin
    b_eff    = 2'd0;
    last_eff = 2'd3;
    case (size)
      2'b00: begin
        b_eff    = addr[1:0];
        last_eff = addr[1:0];
      end
      2'b01: begin
        b_eff    = {addr[1], 1'b0};
        last_eff = {addr[1], 1'b1};
      end
      default: begin
        b_eff    = 2'd0;
        last_eff = 2'd3;
      end
    endcase
  end

`ifdef MA_MISALIGN_TRAP_EN
  assign misalign = (load | store) &
                    (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign shifted = rdata >> {byte_q, 3'b000};

  always_comb begin
    load_result = shifted;
    case (size_q)
      2'b00:   load_result = {{(DWIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_result = {{(DWIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_result = rdata;
    endcase
  end

`ifdef MA_MISALIGN_TRAP_EN
  logic err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      byte_q      <= 2'd0;
      cnt         <= 2'd0;
      last        <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
`ifdef MA_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr_q  <= addr[AWIDTH_MEM+1:2];
            size_q      <= size;
            uns_q       <= is_unsigned;
            byte_q      <= b_eff;
            cnt         <= b_eff;
            last        <= last_eff;
            data_q      <= '0;
            mem_wdata_q <= '0;
`ifdef MA_MISALIGN_TRAP_EN
            err_q       <= misalign;
`endif
            if (misalign) begin
              state <= S_DONE;
            end else if (store) begin
              mem_wdata_q <= wdata << {b_eff, 3'b000};
              state       <= S_STORE;
            end else if (load) begin
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          data_q <= load_result;
          state  <= S_DONE;
        end
        S_STORE: begin
          // One byte lane per cycle: the memory can only commit a single byte per write.
          if (cnt == last) begin
            mem_wdata_q <= '0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign ce        = (state == S_LOAD) | (state == S_STORE);
  assign wr_en     = (state == S_STORE);
  assign mask      = (state == S_STORE) ? (4'b0001 << cnt) : 4'b0000;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state == S_DONE);
  assign data      = data_q;
`ifdef MA_MISALIGN_TRAP_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

module mem_access_unit #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 8
) (
  input  logic                  ma_clk,
  input  logic                  ma_rst,
  input  logic                  ma_i_valid_1,
  output logic                  ma_o_ready_1,
  input  logic                  ma_i_load_1,
  input  logic                  ma_i_store_1,
  input  logic [1:0]            ma_i_size_1,
  input  logic                  ma_i_unsigned_1,
  input  logic [AWIDTH_MEM+1:0] ma_i_addr_1,
  input  logic [DWIDTH-1:0]     ma_i_wdata_1,
  output logic                  ma_o_ce_1,
  output logic                  ma_o_wr_en_1,
  output logic [3:0]            ma_o_mask_1,
  output logic [AWIDTH_MEM-1:0] ma_o_mem_addr_1,
  output logic [DWIDTH-1:0]     ma_o_mem_wdata_1,
  input  logic [DWIDTH-1:0]     ma_i_rdata_1,
  output logic                  ma_o_valid_1,
  output logic [DWIDTH-1:0]     ma_o_data_1,
  output logic                  ma_o_err_1,
  input  logic                  ma_i_valid_2,
  output logic                  ma_o_ready_2,
  input  logic                  ma_i_load_2,
  input  logic                  ma_i_store_2,
  input  logic [1:0]            ma_i_size_2,
  input  logic                  ma_i_unsigned_2,
  input  logic [AWIDTH_MEM+1:0] ma_i_addr_2,
  input  logic [DWIDTH-1:0]     ma_i_wdata_2,
  output logic                  ma_o_ce_2,
  output logic                  ma_o_wr_en_2,
  output logic [3:0]            ma_o_mask_2,
  output logic [AWIDTH_MEM-1:0] ma_o_mem_addr_2,
  output logic [DWIDTH-1:0]     ma_o_mem_wdata_2,
  input  logic [DWIDTH-1:0]     ma_i_rdata_2,
  output logic                  ma_o_valid_2,
  output logic [DWIDTH-1:0]     ma_o_data_2,
  output logic                  ma_o_err_2
);

  mem_access_lane #(.DWIDTH(DWIDTH), .AWIDTH_MEM(AWIDTH_MEM)) u_lane_1 (
    .clk         (ma_clk),
    .rst_n       (ma_rst),
    .req_valid   (ma_i_valid_1),
    .ready       (ma_o_ready_1),
    .load        (ma_i_load_1),
    .store       (ma_i_store_1),
    .size        (ma_i_size_1),
    .is_unsigned (ma_i_unsigned_1),
    .addr        (ma_i_addr_1),
    .wdata       (ma_i_wdata_1),
    .ce          (ma_o_ce_1),
    .wr_en       (ma_o_wr_en_1),
    .mask        (ma_o_mask_1),
    .mem_addr    (ma_o_mem_addr_1),
    .mem_wdata   (ma_o_mem_wdata_1),
    .rdata       (ma_i_rdata_1),
    .done        (ma_o_valid_1),
    .data        (ma_o_data_1),
    .err         (ma_o_err_1)
  );

  mem_access_lane #(.DWIDTH(DWIDTH), .AWIDTH_MEM(AWIDTH_MEM)) u_lane_2 (
    .clk         (ma_clk),
    .rst_n       (ma_rst),
    .req_valid   (ma_i_valid_2),
    .ready       (ma_o_ready_2),
    .load        (ma_i_load_2),
    .store       (ma_i_store_2),
    .size        (ma_i_size_2),
    .is_unsigned (ma_i_unsigned_2),
    .addr        (ma_i_addr_2),
    .wdata       (ma_i_wdata_2),
    .ce          (ma_o_ce_2),
    .wr_en       (ma_o_wr_en_2),
    .mask        (ma_o_mask_2),
    .mem_addr    (ma_o_mem_addr_2),
    .mem_wdata   (ma_o_mem_wdata_2),
    .rdata       (ma_i_rdata_2),
    .done        (ma_o_valid_2),
    .data        (ma_o_data_2),
    .err         (ma_o_err_2)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a byte-write memory model

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_1, load_1, store_1, uns_1, valid_2, load_2, store_2, uns_2;
  logic [1:0]  size_1, size_2;
  logic [9:0]  addr_1, addr_2;
  logic [31:0] wdata_1, wdata_2, rdata_1, rdata_2;
  logic        ready_1, ce_1, wr_en_1, ovalid_1, err_1;
  logic        ready_2, ce_2, wr_en_2, ovalid_2, err_2;
  logic [3:0]  mask_1, mask_2;
  logic [7:0]  mem_addr_1, mem_addr_2;
  logic [31:0] mem_wdata_1, mem_wdata_2, data_1, data_2;

  logic [31:0] mem [0:255] = '{default: '0};
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DWIDTH(32), .AWIDTH_MEM(8)) dut (
    .ma_clk(clk), .ma_rst(rst_n),
    .ma_i_valid_1(valid_1), .ma_o_ready_1(ready_1), .ma_i_load_1(load_1), .ma_i_store_1(store_1),
    .ma_i_size_1(size_1), .ma_i_unsigned_1(uns_1), .ma_i_addr_1(addr_1), .ma_i_wdata_1(wdata_1),
    .ma_o_ce_1(ce_1), .ma_o_wr_en_1(wr_en_1), .ma_o_mask_1(mask_1), .ma_o_mem_addr_1(mem_addr_1),
    .ma_o_mem_wdata_1(mem_wdata_1), .ma_i_rdata_1(rdata_1), .ma_o_valid_1(ovalid_1),
    .ma_o_data_1(data_1), .ma_o_err_1(err_1),
    .ma_i_valid_2(valid_2), .ma_o_ready_2(ready_2), .ma_i_load_2(load_2), .ma_i_store_2(store_2),
    .ma_i_size_2(size_2), .ma_i_unsigned_2(uns_2), .ma_i_addr_2(addr_2), .ma_i_wdata_2(wdata_2),
    .ma_o_ce_2(ce_2), .ma_o_wr_en_2(wr_en_2), .ma_o_mask_2(mask_2), .ma_o_mem_addr_2(mem_addr_2),
    .ma_o_mem_wdata_2(mem_wdata_2), .ma_i_rdata_2(rdata_2), .ma_o_valid_2(ovalid_2),
    .ma_o_data_2(data_2), .ma_o_err_2(err_2)
  );

  // Memory commits enabled byte lanes on the falling edge and reads asynchronously.
  assign rdata_1 = mem[mem_addr_1];
  assign rdata_2 = mem[mem_addr_2];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ce_1 && wr_en_1 && mask_1[i]) mem[mem_addr_1][8*i +: 8] <= mem_wdata_1[8*i +: 8];
      if (ce_2 && wr_en_2 && mask_2[i]) mem[mem_addr_2][8*i +: 8] <= mem_wdata_2[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic u, input logic [9:0] a, input logic [31:0] wd);
    valid_1 = v; load_1 = ld; store_1 = st; size_1 = sz; uns_1 = u; addr_1 = a; wdata_1 = wd;
  endtask

  task automatic drive2(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic u, input logic [9:0] a, input logic [31:0] wd);
    valid_2 = v; load_2 = ld; store_2 = st; size_2 = sz; uns_2 = u; addr_2 = a; wdata_2 = wd;
  endtask

  task automatic load1(input string tag, input logic [1:0] sz, input logic u,
                       input logic [9:0] a, input logic [31:0] exp);
    drive1(1'b1, 1'b1, 1'b0, sz, u, a, 32'h0);
    tick();
    valid_1 = 1'b0;
    chk({tag, "_ce"}, ce_1, 1);
    chk({tag, "_wr"}, wr_en_1, 0);
    chk({tag, "_mask"}, mask_1, 0);
    chk({tag, "_maddr"}, mem_addr_1, a[9:2]);
    chk({tag, "_early"}, ovalid_1, 0);
    tick();
    chk({tag, "_valid"}, ovalid_1, 1);
    chk({tag, "_data"}, data_1, exp);
    chk({tag, "_err"}, err_1, 0);
    chk({tag, "_busy"}, ready_1, 0);
    tick();
    chk({tag, "_ready"}, ready_1, 1);
  endtask

  logic        seen, e_cap;
  logic [31:0] d_cap;

  initial begin
    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    tick(); tick();
    chk("rst_ready1", ready_1, 1);
    chk("rst_ready2", ready_2, 1);
    chk("rst_ce", {ce_1, wr_en_1, ce_2, wr_en_2}, 0);
    chk("rst_mask", {mask_1, mask_2}, 0);
    chk("rst_maddr", {mem_addr_1, mem_addr_2}, 0);
    chk("rst_wdata", mem_wdata_1 | mem_wdata_2, 0);
    chk("rst_valid", {ovalid_1, ovalid_2, err_1, err_2}, 0);
    chk("rst_data", data_1 | data_2, 0);
    rst_n = 1'b1;
    tick();

    // SW 0xA1B2C3D4 to byte address 0x10: four single-byte cycles, ascending lanes.
    drive1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 10'h010, 32'hA1B2C3D4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      valid_1 = 1'b0;
      chk("sw_ce", {ce_1, wr_en_1}, 2'b11);
      chk("sw_mask", mask_1, 32'h1 << (k - 1));
      chk("sw_maddr", mem_addr_1, 8'h04);
      chk("sw_wdata", mem_wdata_1, 32'hA1B2C3D4);
      chk("sw_novalid", ovalid_1, 0);
    end
    tick();
    chk("sw_valid", ovalid_1, 1);
    chk("sw_done_ce", {ce_1, wr_en_1, mask_1}, 0);
    chk("sw_done_data", data_1, 0);
    chk("sw_done_ready", ready_1, 0);
    tick();
    chk("sw_idle", {ready_1, ovalid_1}, 2'b10);
    chk("sw_mem", mem[4], 32'hA1B2C3D4);

    load1("lb", 2'b00, 1'b0, 10'h013, 32'hFFFFFFA1);
    load1("lbu", 2'b00, 1'b1, 10'h013, 32'h000000A1);
    load1("lh", 2'b01, 1'b0, 10'h012, 32'hFFFFA1B2);
    load1("lhu", 2'b01, 1'b1, 10'h010, 32'h0000C3D4);
    load1("lb0", 2'b00, 1'b0, 10'h010, 32'hFFFFFFD4);

    // Lane 2 SH 0x1234 at 0x0A alongside a lane-1 LW at 0x10.
    drive2(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 10'h00A, 32'h00001234);
    drive1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    tick();
    valid_1 = 1'b0; valid_2 = 1'b0;
    chk("sh_mask0", mask_2, 4'b0100);
    chk("sh_maddr", mem_addr_2, 8'h02);
    chk("sh_wdata", mem_wdata_2, 32'h12340000);
    chk("lw_par_ce", {ce_1, wr_en_1, mask_1}, 6'b100000);
    tick();
    chk("sh_mask1", mask_2, 4'b1000);
    chk("sh_wdata1", mem_wdata_2, 32'h12340000);
    chk("lw_par_valid", ovalid_1, 1);
    chk("lw_par_data", data_1, 32'hA1B2C3D4);
    tick();
    chk("sh_valid", {ovalid_2, err_2}, 2'b10);
    chk("sh_data", data_2, 0);
    chk("lw_par_idle", {ready_1, ovalid_1}, 2'b10);
    tick();
    chk("sh_mem", mem[2], 32'h12340000);
    chk("sh_ready", ready_2, 1);

    // Lane 2 SB 0x5A at 0x01.
    drive2(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 10'h001, 32'h0000005A);
    tick();
    valid_2 = 1'b0;
    chk("sb_mask", mask_2, 4'b0010);
    chk("sb_wdata", mem_wdata_2, 32'h00005A00);
    tick();
    chk("sb_valid", ovalid_2, 1);
    tick();
    chk("sb_mem", mem[0], 32'h00005A00);

    // Request with neither load nor store completes next cycle with nothing.
    drive1(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 10'h013, 32'hFFFFFFFF);
    tick();
    valid_1 = 1'b0;
    chk("nop_valid", {ovalid_1, err_1, ce_1}, 3'b100);
    chk("nop_data", data_1, 0);
    tick();
    chk("nop_ready", ready_1, 1);

`ifdef MA_MISALIGN_TRAP_EN
    drive1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h002, 32'h0);
    seen = 1'b0; e_cap = 1'b0; d_cap = 32'hDEADBEEF;
    for (int k = 0; k < 2 && !seen; k++) begin
      tick();
      valid_1 = 1'b0;
      chk("trap_ce", ce_1, 0);
      if (ovalid_1) begin
        seen = 1'b1; e_cap = err_1; d_cap = data_1;
      end
    end
    chk("trap_valid", seen, 1);
    chk("trap_err", e_cap, 1);
    chk("trap_data", d_cap, 0);
    tick(); tick();
    chk("trap_ready", ready_1, 1);
`else
    load1("lw_unal", 2'b10, 1'b0, 10'h002, 32'h00005A00);
`endif

    // Reset during the second byte of a SW: byte 0 stays written, nothing else.
    drive1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h11223344);
    tick();
    valid_1 = 1'b0;
    chk("rsw_mask0", mask_1, 4'b0001);
    tick();
    chk("rsw_mask1", mask_1, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsw_async_ce", {ce_1, wr_en_1, mask_1}, 0);
    chk("rsw_async_out", mem_wdata_1 | {24'h0, mem_addr_1} | data_1, 0);
    chk("rsw_async_rdy", {ready_1, ovalid_1}, 2'b10);
    tick();
    chk("rsw_hold", {ready_1, ovalid_1, ce_1}, 3'b100);
    rst_n = 1'b1;
    tick();
    chk("rsw_after", {ready_1, ovalid_1, ce_1}, 3'b100);
    chk("rsw_mem", mem[8], 32'h00000044);
    load1("rsw_lw", 2'b10, 1'b0, 10'h020, 32'h00000044);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
